// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the framed serial transmitter.
package serial_frame_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  // Frame length in clocks: start + 8 data + optional parity + stop.
  function automatic int frame_clks(input int clks_per_bit, input int parity_en);
    return (10 + parity_en) * clks_per_bit;
  endfunction

  function automatic logic calc_parity(input logic [DATA_W-1:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Per-bit clock divider: counts 0..CLKS_PER_BIT-1 and flags the wrap clock.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  logic [7:0] count_r;

  // Bit-period counter, held at zero while cleared.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_r <= 8'd0;
    end else if (count_r == LAST) begin
      count_r <= 8'd0;
    end else begin
      count_r <= count_r + 8'd1;
    end
  end

  assign tick = (count_r == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, 8 data bits (LSB or MSB first),
// optional parity, stop bit; each bit held CLKS_PER_BIT clocks.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [DATA_W-1:0] data,
  input  logic              msb_first,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  state_e            state_r, state_s;
  logic [DATA_W-1:0] data_r, data_s;
  logic              msb_r, msb_s;
  logic [2:0]        bit_idx_r, bit_idx_s;
  logic              tx_r, tx_s;
  logic              tick_s;
  logic              clear_s;

  // Timer is held cleared in IDLE so the start bit gets a full period.
  assign clear_s = (state_r == IDLE);

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .clear (clear_s),
    .tick  (tick_s)
  );

  // Next-state, capture and bit-index logic.
  always_comb begin
    state_s   = state_r;
    data_s    = data_r;
    msb_s     = msb_r;
    bit_idx_s = bit_idx_r;
    case (state_r)
      IDLE: begin
        if (data_valid) begin
          state_s   = START;
          data_s    = data;
          msb_s     = msb_first;
          bit_idx_s = 3'd0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (tick_s) state_s = DATA;
        else        state_s = START;
      end
      DATA: begin
        if (tick_s) begin
          if (bit_idx_r == 3'd7) begin
            bit_idx_s = 3'd0;
            state_s   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (tick_s) state_s = STOP;
        else        state_s = PARITY;
      end
      STOP: begin
        if (tick_s) state_s = IDLE;
        else        state_s = STOP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Line level for the upcoming clock, decoded from next state so tx stays registered.
  always_comb begin
    tx_s = 1'b1;
    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = msb_s ? data_s[3'd7 - bit_idx_s] : data_s[bit_idx_s];
      PARITY:  tx_s = calc_parity(data_s, (PARITY_ODD != 0));
      STOP:    tx_s = 1'b1;
      default: tx_s = 1'b1;
    endcase
  end

  // State, capture and line registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      data_r    <= '0;
      msb_r     <= 1'b0;
      bit_idx_r <= 3'd0;
      tx_r      <= 1'b1;
    end else begin
      state_r   <= state_s;
      data_r    <= data_s;
      msb_r     <= msb_s;
      bit_idx_r <= bit_idx_s;
      tx_r      <= tx_s;
    end
  end

  assign tx         = tx_r;
  assign data_ready = (state_r == IDLE);
  assign busy       = (state_r != IDLE);
  assign frame_done = (state_r == STOP) && tick_s;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx across four parameter sets.
module tb_serial_frame_tx;
  import serial_frame_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] dv, rdy, msb, txv, bsy, fd;
  logic [7:0] din [4];

  int cpb_cfg [4] = '{2, 2, 2, 1};
  int pe_cfg  [4] = '{1, 1, 0, 1};
  int po_cfg  [4] = '{0, 1, 0, 0};

  int checks   = 0;
  int failures = 0;

  logic exp_tx [$];
  logic exp_fd [$];
  logic exp_bs [$];

  always #5 clk = ~clk;

  serial_frame_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .reset(reset), .data_valid(dv[0]), .data_ready(rdy[0]), .data(din[0]),
    .msb_first(msb[0]), .tx(txv[0]), .busy(bsy[0]), .frame_done(fd[0]));
  serial_frame_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .reset(reset), .data_valid(dv[1]), .data_ready(rdy[1]), .data(din[1]),
    .msb_first(msb[1]), .tx(txv[1]), .busy(bsy[1]), .frame_done(fd[1]));
  serial_frame_tx #(.CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0)) u_nopar (
    .clk(clk), .reset(reset), .data_valid(dv[2]), .data_ready(rdy[2]), .data(din[2]),
    .msb_first(msb[2]), .tx(txv[2]), .busy(bsy[2]), .frame_done(fd[2]));
  serial_frame_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0)) u_fast (
    .clk(clk), .reset(reset), .data_valid(dv[3]), .data_ready(rdy[3]), .data(din[3]),
    .msb_first(msb[3]), .tx(txv[3]), .busy(bsy[3]), .frame_done(fd[3]));

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_slot(input logic t, input logic f, input logic b);
    exp_tx.push_back(t);
    exp_fd.push_back(f);
    exp_bs.push_back(b);
  endtask

  // Reference frame model: independent of the DUT's FSM encoding.
  task automatic push_frame(input int k, input logic [7:0] d, input logic m);
    logic bitv;
    for (int j = 0; j < cpb_cfg[k]; j++) push_slot(1'b0, 1'b0, 1'b1);
    for (int b = 0; b < 8; b++) begin
      bitv = m ? d[7-b] : d[b];
      for (int j = 0; j < cpb_cfg[k]; j++) push_slot(bitv, 1'b0, 1'b1);
    end
    if (pe_cfg[k] != 0) begin
      bitv = (^d) ^ po_cfg[k][0];
      for (int j = 0; j < cpb_cfg[k]; j++) push_slot(bitv, 1'b0, 1'b1);
    end
    for (int j = 0; j < cpb_cfg[k]; j++) push_slot(1'b1, (j == cpb_cfg[k] - 1), 1'b1);
    push_slot(1'b1, 1'b0, 1'b0);
  endtask

  // Offer a word at a negedge; returns at the negedge after the accepting edge.
  task automatic start_frame(input int k, input logic [7:0] d, input logic m);
    dv[k]  = 1'b1;
    din[k] = d;
    msb[k] = m;
    check_val($sformatf("ready_before_accept[%0d]", k), rdy[k], 1);
    push_frame(k, d, m);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pop and compare one expected slot per clock; drops valid at drop_at and
  // scrambles the input word five clocks later to prove it is ignored.
  task automatic drain(input int k, input int drop_at, input int limit, input int exp_len);
    int busy_cnt = 0;
    for (int i = 0; i < limit && exp_tx.size() > 0; i++) begin
      if (i == drop_at) dv[k] = 1'b0;
      if (i == drop_at + 5) begin
        din[k] = 8'h00;
        msb[k] = ~msb[k];
      end
      check_val($sformatf("tx[%0d]@%0d", k, i), txv[k], exp_tx[0]);
      check_val($sformatf("frame_done[%0d]@%0d", k, i), fd[k], exp_fd[0]);
      check_val($sformatf("busy[%0d]@%0d", k, i), bsy[k], exp_bs[0]);
      check_val($sformatf("ready[%0d]@%0d", k, i), rdy[k], !exp_bs[0]);
      if (bsy[k]) busy_cnt++;
      void'(exp_tx.pop_front());
      void'(exp_fd.pop_front());
      void'(exp_bs.pop_front());
      @(negedge clk);
    end
    if (exp_len > 0) check_val($sformatf("frame_len[%0d]", k), busy_cnt, exp_len);
  endtask

  initial begin
    reset = 1'b1;
    dv    = 4'b0000;
    msb   = 4'b0000;
    for (int k = 0; k < 4; k++) din[k] = 8'h00;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < 4; k++) begin
        check_val($sformatf("idle_tx[%0d]", k), txv[k], 1);
        check_val($sformatf("idle_ready[%0d]", k), rdy[k], 1);
        check_val($sformatf("idle_busy[%0d]", k), bsy[k], 0);
        check_val($sformatf("idle_done[%0d]", k), fd[k], 0);
      end
      @(negedge clk);
    end

    // LSB-first A5, then MSB-first F3, even parity, 2 clocks per bit
    start_frame(0, 8'hA5, 1'b0);
    drain(0, 0, 1000, frame_clks(2, 1));
    start_frame(0, 8'hF3, 1'b1);
    drain(0, 0, 1000, frame_clks(2, 1));

    // Odd parity on 00, and a frame without a parity slot
    start_frame(1, 8'h00, 1'b0);
    drain(1, 0, 1000, frame_clks(2, 1));
    start_frame(2, 8'h81, 1'b0);
    drain(2, 0, 1000, frame_clks(2, 0));

    // Back-to-back with valid held high at 1 clock per bit
    start_frame(3, 8'h01, 1'b0);
    din[3] = 8'h80;
    push_frame(3, 8'h80, 1'b0);
    void'(exp_tx.pop_back());
    void'(exp_fd.pop_back());
    void'(exp_bs.pop_back());
    push_slot(1'b1, 1'b0, 1'b0);
    drain(3, 12, 1000, 0);

    // Reset during data bit 3
    start_frame(0, 8'h5A, 1'b0);
    drain(0, 0, 8, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_val("abort_tx", txv[0], 1);
    check_val("abort_ready", rdy[0], 1);
    check_val("abort_busy", bsy[0], 0);
    check_val("abort_done", fd[0], 0);
    exp_tx.delete();
    exp_fd.delete();
    exp_bs.delete();
    start_frame(0, 8'h3C, 1'b1);
    drain(0, 0, 1000, frame_clks(2, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
